// File: rtl/gemm_tile_sequencer.sv
// Tile sequencer for a systolic GEMM array: fetches weights and inputs per tile over DMA,
// then steps the array through weight load, compute and drain. All outputs are registered.
module gemm_tile_sequencer #(
    parameter int unsigned ARRAY_DIM = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_ROWS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_inp_base,
    input  logic [15:0]       cfg_num_tiles,
    input  logic [7:0]        cfg_inp_rows,
    output logic              dma_req_valid,
    input  logic              dma_req_ready,
    output logic [ADDR_W-1:0] dma_req_addr,
    output logic [15:0]       dma_req_len,
    input  logic              dma_done,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              wgt_we,
    output logic              inp_we,
    output logic [15:0]       buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              arr_en,
    output logic              arr_load_weight,
    output logic              arr_ifmap_valid,
    output logic [7:0]        arr_row,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              irq
);

    localparam logic [15:0]       WgtLen    = 16'(ARRAY_DIM * ARRAY_DIM);
    localparam logic [15:0]       DimW      = 16'(ARRAY_DIM);
    localparam logic [15:0]       LoadLast  = 16'(ARRAY_DIM - 1);
    localparam logic [15:0]       DrainLast = 16'(2 * ARRAY_DIM - 2);
    localparam logic [15:0]       MaxRows   = 16'(MAX_ROWS);
    localparam logic [ADDR_W-1:0] WgtStride = ADDR_W'(ARRAY_DIM * ARRAY_DIM * 4);

    typedef enum logic [3:0] {
        StIdle, StReqW, StFetchW, StReqI, StFetchI, StLoad, StCompute, StDrain, StNext, StFin
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       tile_q, tile_d, tiles_q, tiles_d, inp_len_q, inp_len_d;
    logic [15:0]       beat_q, beat_d, cyc_q, cyc_d;
    logic [7:0]        rows_q, rows_d;
    logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d, inp_addr_q, inp_addr_d;

    logic              dma_req_valid_q, dma_req_valid_d, s_ready_q, s_ready_d;
    logic [ADDR_W-1:0] dma_req_addr_q, dma_req_addr_d;
    logic [15:0]       dma_req_len_q, dma_req_len_d, buf_waddr_q, buf_waddr_d;
    logic              wgt_we_q, wgt_we_d, inp_we_q, inp_we_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic              arr_en_q, arr_en_d, arr_lw_q, arr_lw_d, arr_iv_q, arr_iv_d;
    logic [7:0]        arr_row_q, arr_row_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;

    logic              fetching, beat_wr;
    logic [15:0]       fetch_len, beat_n, tile_n;

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        tiles_d     = tiles_q;
        rows_d      = rows_q;
        inp_len_d   = inp_len_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        wgt_addr_d  = wgt_addr_q;
        inp_addr_d  = inp_addr_q;
        done_d      = done_q;
        err_d       = err_q;
        wgt_we_d    = 1'b0;
        inp_we_d    = 1'b0;
        buf_waddr_d = '0;
        buf_wdata_d = '0;

        fetching  = (state_q == StFetchW) || (state_q == StFetchI);
        fetch_len = (state_q == StFetchW) ? WgtLen : inp_len_q;
        // Beats past the expected count are accepted but neither written nor counted.
        beat_wr   = fetching && s_valid && s_ready_q && (beat_q < fetch_len);
        beat_n    = beat_q + 16'(beat_wr);
        tile_n    = tile_q + 16'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (cfg_num_tiles == 16'd0) begin
                        state_d = StFin;
                    end else if (cfg_inp_rows == 8'd0 || {8'd0, cfg_inp_rows} > MaxRows) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        tiles_d    = cfg_num_tiles;
                        rows_d     = cfg_inp_rows;
                        inp_len_d  = 16'(cfg_inp_rows) * DimW;
                        wgt_addr_d = cfg_wgt_base;
                        inp_addr_d = cfg_inp_base;
                        tile_d     = '0;
                        state_d    = StReqW;
                    end
                end
            end
            StReqW, StReqI: begin
                if (dma_req_valid_q && dma_req_ready) begin
                    beat_d  = '0;
                    state_d = (state_q == StReqW) ? StFetchW : StFetchI;
                end
            end
            StFetchW, StFetchI: begin
                beat_d = beat_n;
                if (beat_wr) begin
                    wgt_we_d    = (state_q == StFetchW);
                    inp_we_d    = (state_q == StFetchI);
                    buf_waddr_d = beat_q;
                    buf_wdata_d = s_data[DATA_W-1:0];
                end
                if (dma_done) begin
                    if (beat_n == fetch_len) begin
                        cyc_d   = '0;
                        state_d = (state_q == StFetchW) ? StReqI : StLoad;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end
                end
            end
            StLoad: begin
                cyc_d = cyc_q + 16'd1;
                if (cyc_q == LoadLast) begin
                    cyc_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                cyc_d = cyc_q + 16'd1;
                if (cyc_q == {8'd0, rows_q} - 16'd1) begin
                    cyc_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cyc_d = cyc_q + 16'd1;
                if (cyc_q == DrainLast) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                tile_d     = tile_n;
                wgt_addr_d = wgt_addr_q + WgtStride;
                inp_addr_d = inp_addr_q + ADDR_W'({inp_len_q, 2'b00});
                state_d    = (tile_n == tiles_q) ? StFin : StReqW;
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d == StFin) begin
            done_d = 1'b1;
        end

        if (abort && state_q != StIdle) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            err_d    = err_q;
            wgt_we_d = 1'b0;
            inp_we_d = 1'b0;
            buf_waddr_d = '0;
            buf_wdata_d = '0;
        end

        // Registered outputs are derived from next state so they line up with state_q.
        dma_req_valid_d = (state_d == StReqW) || (state_d == StReqI);
        dma_req_addr_d  = (state_d == StReqW) ? wgt_addr_d :
                          (state_d == StReqI) ? inp_addr_d : '0;
        dma_req_len_d   = (state_d == StReqW) ? WgtLen :
                          (state_d == StReqI) ? inp_len_d : '0;
        s_ready_d       = (state_d == StFetchW) || (state_d == StFetchI);
        arr_lw_d        = (state_d == StLoad);
        arr_iv_d        = (state_d == StCompute);
        arr_en_d        = arr_lw_d || arr_iv_d || (state_d == StDrain);
        arr_row_d       = (arr_lw_d || arr_iv_d) ? cyc_d[7:0] : 8'd0;
        busy_d          = (state_d != StIdle) && (state_d != StFin);
        irq_d           = (state_d == StFin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            tile_q          <= '0;
            tiles_q         <= '0;
            rows_q          <= '0;
            inp_len_q       <= '0;
            beat_q          <= '0;
            cyc_q           <= '0;
            wgt_addr_q      <= '0;
            inp_addr_q      <= '0;
            dma_req_valid_q <= 1'b0;
            dma_req_addr_q  <= '0;
            dma_req_len_q   <= '0;
            s_ready_q       <= 1'b0;
            wgt_we_q        <= 1'b0;
            inp_we_q        <= 1'b0;
            buf_waddr_q     <= '0;
            buf_wdata_q     <= '0;
            arr_en_q        <= 1'b0;
            arr_lw_q        <= 1'b0;
            arr_iv_q        <= 1'b0;
            arr_row_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            tile_q          <= tile_d;
            tiles_q         <= tiles_d;
            rows_q          <= rows_d;
            inp_len_q       <= inp_len_d;
            beat_q          <= beat_d;
            cyc_q           <= cyc_d;
            wgt_addr_q      <= wgt_addr_d;
            inp_addr_q      <= inp_addr_d;
            dma_req_valid_q <= dma_req_valid_d;
            dma_req_addr_q  <= dma_req_addr_d;
            dma_req_len_q   <= dma_req_len_d;
            s_ready_q       <= s_ready_d;
            wgt_we_q        <= wgt_we_d;
            inp_we_q        <= inp_we_d;
            buf_waddr_q     <= buf_waddr_d;
            buf_wdata_q     <= buf_wdata_d;
            arr_en_q        <= arr_en_d;
            arr_lw_q        <= arr_lw_d;
            arr_iv_q        <= arr_iv_d;
            arr_row_q       <= arr_row_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            irq_q           <= irq_d;
        end
    end

    assign dma_req_valid   = dma_req_valid_q;
    assign dma_req_addr    = dma_req_addr_q;
    assign dma_req_len     = dma_req_len_q;
    assign s_ready         = s_ready_q;
    assign wgt_we          = wgt_we_q;
    assign inp_we          = inp_we_q;
    assign buf_waddr       = buf_waddr_q;
    assign buf_wdata       = buf_wdata_q;
    assign arr_en          = arr_en_q;
    assign arr_load_weight = arr_lw_q;
    assign arr_ifmap_valid = arr_iv_q;
    assign arr_row         = arr_row_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer (ARRAY_DIM=4) with request and buffer-write
// scoreboards fed by the stimulus and drained by a negedge monitor.
module tb_gemm_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] cfg_wgt_base = '0, cfg_inp_base = '0;
    logic [15:0] cfg_num_tiles = '0;
    logic [7:0]  cfg_inp_rows = '0;
    logic        dma_req_valid, dma_req_ready = 1'b0, dma_done = 1'b0;
    logic [31:0] dma_req_addr;
    logic [15:0] dma_req_len;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_data = '0;
    logic        wgt_we, inp_we;
    logic [15:0] buf_waddr;
    logic [7:0]  buf_wdata;
    logic        arr_en, arr_load_weight, arr_ifmap_valid;
    logic [7:0]  arr_row;
    logic        busy, done, err, irq;

    gemm_tile_sequencer #(.ARRAY_DIM(4), .DATA_W(8), .ADDR_W(32), .MAX_ROWS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_wgt_base(cfg_wgt_base), .cfg_inp_base(cfg_inp_base),
        .cfg_num_tiles(cfg_num_tiles), .cfg_inp_rows(cfg_inp_rows),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_addr(dma_req_addr), .dma_req_len(dma_req_len), .dma_done(dma_done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wgt_we(wgt_we), .inp_we(inp_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .arr_en(arr_en), .arr_load_weight(arr_load_weight), .arr_ifmap_valid(arr_ifmap_valid),
        .arr_row(arr_row), .busy(busy), .done(done), .err(err), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int hs_cnt = 0, irq_cnt = 0, n_load = 0, n_comp = 0, n_drain = 0;
    int ld_row = 0, cmp_row = 0;
    logic [24:0] wr_q[$];   // {is_wgt, addr, data}
    logic [47:0] req_q[$];  // {addr, len}
    logic [24:0] wr_e;
    logic [47:0] req_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wgt_we || inp_we) begin
                check("wr_pending", 64'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    wr_e = wr_q.pop_front();
                    check("wr_sel", {wgt_we, inp_we}, {wr_e[24], ~wr_e[24]});
                    check("wr_addr", buf_waddr, wr_e[23:8]);
                    check("wr_data", buf_wdata, wr_e[7:0]);
                end
            end
            if (dma_req_valid && dma_req_ready) begin
                hs_cnt++;
                check("req_pending", 64'(req_q.size() > 0), 1);
                if (req_q.size() > 0) begin
                    req_e = req_q.pop_front();
                    check("req_addr", dma_req_addr, req_e[47:16]);
                    check("req_len", dma_req_len, req_e[15:0]);
                end
            end
            if (irq) irq_cnt++;
            if (arr_load_weight) begin
                check("load_row", arr_row, 8'(ld_row));
                ld_row++;
                n_load++;
            end else ld_row = 0;
            if (arr_ifmap_valid) begin
                check("comp_row", arr_row, 8'(cmp_row));
                cmp_row++;
                n_comp++;
            end else cmp_row = 0;
            if (arr_en && !arr_load_weight && !arr_ifmap_valid) n_drain++;
        end
    end

    task automatic do_start(input int tiles, input int rows, input logic [31:0] wb,
                            input logic [31:0] ib);
        @(posedge clk); #1;
        cfg_num_tiles = 16'(tiles);
        cfg_inp_rows  = 8'(rows);
        cfg_wgt_base  = wb;
        cfg_inp_base  = ib;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode: 0 = dma_done after the beats, 1 = dma_done with the last beat, 2 = no dma_done
    task automatic serve(input int nbeats, input int explen, input bit wgt, input int hold,
                         input int mode);
        int w = 0;
        int hs0;
        logic [31:0] a0;
        logic [15:0] l0;
        @(negedge clk);
        while (!dma_req_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("req_valid", dma_req_valid, 1);
        if (!dma_req_valid) return;
        hs0 = hs_cnt;
        a0  = dma_req_addr;
        l0  = dma_req_len;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", dma_req_valid, 1);
            check("hold_addr", dma_req_addr, a0);
            check("hold_len", dma_req_len, l0);
        end
        @(posedge clk); #1 dma_req_ready = 1'b1;
        @(posedge clk); #1 dma_req_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            if (i < explen) wr_q.push_back({wgt, 16'(i), s_data[7:0]});
            dma_done = (mode == 1) && (i == nbeats - 1);
            @(posedge clk); #1;
        end
        s_valid  = 1'b0;
        dma_done = 1'b0;
        if (mode == 0) begin
            dma_done = 1'b1;
            @(posedge clk); #1 dma_done = 1'b0;
        end
        check("hs_once", hs_cnt, hs0 + 1);
    endtask

    task automatic wait_irq(input int irq0);
        int w = 0;
        while (irq_cnt == irq0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check("irq_once", irq_cnt - irq0, 1);
    endtask

    int i0, l0, c0, d0, h0, w;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_valid", dma_req_valid, 0);
        check("rst_req_addr", dma_req_addr, 0);
        check("rst_req_len", dma_req_len, 0);
        check("rst_status", {busy, done, err, irq, s_ready, arr_en}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Two-tile job with a stray start while busy and a stalled second weight request
        i0 = irq_cnt; l0 = n_load; c0 = n_comp; d0 = n_drain; h0 = hs_cnt;
        req_q.push_back({32'h1000, 16'd16});
        req_q.push_back({32'h2000, 16'd12});
        req_q.push_back({32'h1040, 16'd16});
        req_q.push_back({32'h2030, 16'd12});
        do_start(2, 3, 32'h1000, 32'h2000);
        do_start(5, 7, 32'h9000, 32'h9800);
        serve(16, 16, 1'b1, 0, 1);
        serve(12, 12, 1'b0, 0, 1);
        serve(16, 16, 1'b1, 5, 1);
        serve(12, 12, 1'b0, 0, 0);
        wait_irq(i0);
        check("job_done", done, 1);
        check("job_err", err, 0);
        check("job_busy", busy, 0);
        check("job_loads", n_load - l0, 8);
        check("job_computes", n_comp - c0, 6);
        check("job_drains", n_drain - d0, 14);
        check("job_handshakes", hs_cnt - h0, 4);

        // Short weight transfer
        i0 = irq_cnt; l0 = n_load;
        req_q.push_back({32'h1000, 16'd16});
        do_start(1, 3, 32'h1000, 32'h2000);
        serve(10, 10, 1'b1, 0, 0);
        wait_irq(i0);
        check("short_err", err, 1);
        check("short_done", done, 1);
        check("short_loads", n_load - l0, 0);
        check("short_no_req", req_q.size(), 0);

        // Abort on compute row 1, then a clean job with surplus weight beats
        i0 = irq_cnt;
        req_q.push_back({32'h3000, 16'd16});
        req_q.push_back({32'h4000, 16'd12});
        do_start(1, 3, 32'h3000, 32'h4000);
        serve(16, 16, 1'b1, 0, 1);
        serve(12, 12, 1'b0, 0, 1);
        w = 0;
        @(negedge clk);
        while (!(arr_ifmap_valid && arr_row == 8'd1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("abort_row1", {arr_ifmap_valid, arr_row}, {1'b1, 8'd1});
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_arr", {arr_en, arr_ifmap_valid, irq}, 0);
        repeat (4) @(negedge clk);
        check("abort_no_irq", irq_cnt - i0, 0);

        i0 = irq_cnt; l0 = n_load; c0 = n_comp; d0 = n_drain;
        req_q.push_back({32'h5000, 16'd16});
        req_q.push_back({32'h6000, 16'd8});
        do_start(1, 2, 32'h5000, 32'h6000);
        serve(18, 16, 1'b1, 0, 1);
        serve(8, 8, 1'b0, 0, 1);
        wait_irq(i0);
        check("rerun_done_err", {done, err}, 2'b10);
        check("rerun_counts", {16'(n_load - l0), 16'(n_comp - c0), 16'(n_drain - d0)},
              {16'd4, 16'd2, 16'd7});

        // Degenerate configurations
        h0 = hs_cnt;
        do_start(0, 3, 32'h0, 32'h0);
        check("zero_tiles_irq", {irq, done, err, busy}, 4'b1100);
        do_start(1, 0, 32'h0, 32'h0);
        check("zero_rows", {irq, done, err}, 3'b111);
        do_start(1, 65, 32'h0, 32'h0);
        check("big_rows", {irq, done, err}, 3'b111);
        repeat (3) @(negedge clk);
        check("degenerate_no_req", hs_cnt - h0, 0);

        // Reset during input fetch
        i0 = irq_cnt;
        req_q.push_back({32'h7000, 16'd16});
        req_q.push_back({32'h8000, 16'd12});
        do_start(1, 3, 32'h7000, 32'h8000);
        serve(16, 16, 1'b1, 0, 1);
        serve(5, 5, 1'b0, 0, 2);
        @(negedge clk);
        check("pre_rst_fetch", {s_ready, busy}, 2'b11);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_now_ctrl", {s_ready, busy, dma_req_valid, wgt_we, inp_we, arr_en}, 0);
        check("rst_now_status", {done, err, irq}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_irq", irq_cnt - i0, 0);
        check("rst_idle", busy, 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("req_q_empty", req_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
